router_port_rx: RTL and testbench
=================================

Name: router_port_rx

Overview:
- Per-port serial receiver on the router input side; sits between the testbench/driver pins (din, frame_n, valid_n, busy_n) and the router switch fabric.
- Decodes the serial packet protocol: 4-bit destination address, pad cycles, then LSB-first payload bytes.
- Emits parallel bytes, tagged with address and SOP/EOP, through a ready/valid FIFO.
- One instance per input port (16 in the router).

Parameters:
- DEPTH, 4: output FIFO entries (power of 2, >=2).
- PAD_CYCLES, 5: mandatory pad cycles between address and payload.
- BUSY_THRESH, 3: FIFO occupancy at or above which busy_n is driven low.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- din  in  1  serial data bit for this port.
- frame_n  in  1  active-low frame; high on the last payload bit.
- valid_n  in  1  active-low payload-bit qualifier.
- busy_n  out  1  low = driver must not start a new frame.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  8  payload byte.
- out_addr  out  4  destination port of packet.
- out_sop  out  1  first byte of packet.
- out_eop  out  1  last byte of packet.
- err_frame  out  1  one-cycle pulse, protocol violation.
- err_ovf  out  1  one-cycle pulse, byte dropped on full FIFO.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. While reset is high the FSM goes to IDLE, the FIFO is emptied, and counters and the shift register clear. Output reset values: out_valid=0, out_data/out_addr/out_sop/out_eop=0, err_*=0, busy_n=1. Reset mid-packet discards the partial packet silently (no err pulse).
- FSM states: IDLE, ADDR, PAD, PAYLOAD.
- IDLE: on a cycle with frame_n=0, sample din as addr[0] and go to ADDR with bit count=1.
- ADDR: sample din into addr[1..3] on the next 3 cycles; valid_n is ignored. After addr[3] go to PAD with pad count=0.
- PAD: lasts exactly PAD_CYCLES cycles, with valid_n=1 required. After the final pad cycle go to PAYLOAD.
- PAYLOAD:
  - Each cycle with valid_n=0 shifts din into bit[n], n=0..7, LSB first.
  - Cycles with valid_n=1 are gaps and are ignored, unless frame_n is also 1.
  - When bit 7 is sampled, the byte completes and is pushed with the latched addr, sop=(first byte of packet), and eop=(frame_n==1 on that cycle).
  - eop push returns the FSM to IDLE; the next frame may start on the following cycle.
- Framing errors pulse err_frame, drop any partial byte and return to IDLE. Bytes already pushed remain in the FIFO; no eop is synthesized. The error conditions are:
  - frame_n=1 in ADDR or PAD;
  - valid_n=0 in PAD;
  - frame_n=1 with a bit count other than 7.
- Minimum payload is 1 byte.
- Latency: out_valid rises on the cycle after bit 7 is sampled (from an empty FIFO).
- FIFO:
  - Pop when out_valid && out_ready.
  - Push on byte completion.
  - Full: a push is accepted only if a pop occurs the same cycle (count unchanged). Otherwise the byte is dropped and err_ovf pulses; packet reception continues and sop/eop tracking is unchanged.
  - Empty: no pop; out_* outputs are held at their last value with out_valid=0.
  - Simultaneous push and pop at any occupancy keeps count constant and preserves order.
- busy_n = 0 when FIFO count >= BUSY_THRESH, registered (one-cycle lag). It does not affect reception; it is advisory to the driver.
- Widths: FIFO entry is 14 bits {addr[3:0], sop, eop, data[7:0]}. Pad and bit counters are $clog2-sized, saturating at no point; they are reset on each state entry.

Decomposition:
- Package router_pkg holds:
  - rx_state_e enum (IDLE, ADDR, PAD, PAYLOAD);
  - rx_entry_t packed struct {addr, sop, eop, data};
  - constants ADDR_W=4, BYTE_W=8, DEF_PAD_CYCLES=5.
- Sub-module router_rx_fifo: parameterised sync FIFO of rx_entry_t with push/pop/full/empty/count. Protocol FSM and shift register live in router_port_rx.

Test Plan:
- Single packet: addr=4'hA, 5 pad cycles, payload {8'h3C, 8'hA5} with no gaps, out_ready=1 -> two beats, data 3C then A5, out_addr=A on both, sop=1/eop=0 then sop=0/eop=1. First out_valid arrives 1 cycle after the 8th bit of 3C.
- Gapped payload: same packet with valid_n=1 for 3 cycles between bits 3 and 4 of 8'h81 -> single byte 81, eop=1, no err pulses.
- Framing error: frame_n=1 after 5 payload bits (frame_n low for addr and pad) -> err_frame pulses once, nothing pushed, FSM in IDLE. A following valid packet addr=3, data 8'h55 is received correctly.
- Overflow/backpressure: out_ready=0, 5-byte packet 01..05, DEPTH=4 -> busy_n low one cycle after 3rd push. Byte 05 is dropped with one err_ovf pulse. Draining yields 01,02,03,04 with sop on 01 and no eop.
- Full with simultaneous pop: FIFO full, out_ready=1 on the cycle byte 8'hF0 completes -> no err_ovf, count stays 4, F0 appears at the tail in order.
- Reset mid-packet: assert reset for 1 cycle during PAD -> all outputs return to reset values, busy_n=1, no err pulse. A subsequent packet addr=0, data 8'h7E is received normally.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router input-port receiver.
// Holds the receiver FSM state enum, the 14-bit FIFO entry and width constants.
package router_pkg;

  localparam int ADDR_W         = 4;
  localparam int BYTE_W         = 8;
  localparam int DEF_PAD_CYCLES = 5;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    PAD,
    PAYLOAD
  } rx_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              sop;
    logic              eop;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// router_rx_fifo: synchronous FIFO of rx_entry_t between receiver and fabric.
// Ports: i_push/i_data write, i_pop read, o_data head, o_full/o_empty/o_count.
module router_rx_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  rx_entry_t              i_data,
  input  logic                   i_pop,
  output rx_entry_t              o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rx_entry_t         r_mem [DEPTH];
  rx_entry_t         r_hold;
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

  // A push into a full FIFO is legal only if the head leaves this cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // When empty, the last popped entry stays visible on the outputs.
  assign o_data = o_empty ? r_hold : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_hold <= r_mem[r_rd];
        r_rd   <= r_rd + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// router_port_rx: serial packet receiver for one router input port.
// Ports: din/frame_n/valid_n serial in, busy_n advisory, out_* FIFO head, err_* pulses.
module router_port_rx
  import router_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PAD_CYCLES  = DEF_PAD_CYCLES,
  parameter int BUSY_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              frame_n,
  input  logic              valid_n,
  output logic              busy_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_sop,
  output logic              out_eop,
  output logic              err_frame,
  output logic              err_ovf
);

  localparam int PW = $clog2(PAD_CYCLES + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  rx_state_e         r_state;
  logic [2:0]        r_bitcnt;
  logic [PW-1:0]     r_padcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [6:0]        r_shift;
  logic              r_first;
  logic              r_err_frame;
  logic              r_err_ovf;
  logic              r_busy_n;

  logic              w_bit7;
  logic              w_perr;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  rx_entry_t         w_entry;
  rx_entry_t         w_head;

  // Bit 7 completes a byte; frame_n high is legal only on that very bit.
  assign w_bit7 = (r_state == PAYLOAD) && !valid_n && (r_bitcnt == 3'd7);
  assign w_perr = (r_state == PAYLOAD) && frame_n && !w_bit7;
  assign w_push = w_bit7;
  assign w_pop  = out_ready && !w_empty;
  assign w_ovf  = w_push && w_full && !w_pop;

  assign w_entry = '{addr: r_addr, sop: r_first, eop: frame_n,
                     data: {din, r_shift}};

  router_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head.data;
  assign out_addr  = w_head.addr;
  assign out_sop   = w_head.sop;
  assign out_eop   = w_head.eop;
  assign err_frame = r_err_frame;
  assign err_ovf   = r_err_ovf;
  assign busy_n    = r_busy_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_padcnt    <= '0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_first     <= 1'b0;
      r_err_frame <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_busy_n    <= 1'b1;
    end else begin
      r_err_frame <= 1'b0;
      r_err_ovf   <= w_ovf;
      r_busy_n    <= !(int'(w_count) >= BUSY_THRESH);
      unique case (r_state)
        IDLE: begin
          if (!frame_n) begin
            r_addr[0] <= din;
            r_bitcnt  <= 3'd1;
            r_first   <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (frame_n) begin
            r_err_frame <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_addr[r_bitcnt[1:0]] <= din;
            if (r_bitcnt == 3'd3) begin
              r_padcnt <= '0;
              r_state  <= PAD;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
        PAD: begin
          if (frame_n || !valid_n) begin
            r_err_frame <= 1'b1;
            r_state     <= IDLE;
          end else if (r_padcnt == PW'(PAD_CYCLES - 1)) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_state  <= PAYLOAD;
          end else begin
            r_padcnt <= r_padcnt + PW'(1);
          end
        end
        PAYLOAD: begin
          if (w_perr) begin
            r_err_frame <= 1'b1;
            r_state     <= IDLE;
          end else if (!valid_n) begin
            r_shift  <= {din, r_shift[6:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_bit7) begin
              r_first <= 1'b0;
              if (frame_n) r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_port_rx.sv
// tb_router_port_rx: random and directed packets against a queue-level model.
// Ports: none; drives router_port_rx pins and checks every output each cycle.
module tb_router_port_rx;
  import router_pkg::*;

  localparam int DEPTH = 4;
  localparam int PADC  = 5;
  localparam int BT    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic       busy_n;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_addr;
  logic       out_sop;
  logic       out_eop;
  logic       err_frame;
  logic       err_ovf;

  always #5 clk = ~clk;

  router_port_rx #(
    .DEPTH       (DEPTH),
    .PAD_CYCLES  (PADC),
    .BUSY_THRESH (BT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .busy_n    (busy_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .err_frame (err_frame),
    .err_ovf   (err_ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Transaction events announced by the driver for the cycle it drives.
  bit        m_en     = 1'b0;
  bit        ev_push  = 1'b0;
  bit        ev_frame = 1'b0;
  bit        ev_rst   = 1'b0;
  rx_entry_t ev_ent   = '0;

  rx_entry_t mq[$];
  rx_entry_t m_last = '0;
  bit        x_busy = 1'b1;
  bit        x_ovf  = 1'b0;
  bit        x_frm  = 1'b0;

  always @(negedge clk) begin
    if (m_en) begin
      rx_entry_t h;
      h = (mq.size() != 0) ? mq[0] : m_last;
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_data",  32'(out_data),  32'(h.data));
      chk("out_addr",  32'(out_addr),  32'(h.addr));
      chk("out_sop",   32'(out_sop),   32'(h.sop));
      chk("out_eop",   32'(out_eop),   32'(h.eop));
      chk("busy_n",    32'(busy_n),    32'(x_busy));
      chk("err_ovf",   32'(err_ovf),   32'(x_ovf));
      chk("err_frame", 32'(err_frame), 32'(x_frm));
      if (ev_rst) begin
        mq.delete();
        m_last = '0;
        x_busy = 1'b1;
        x_ovf  = 1'b0;
        x_frm  = 1'b0;
      end else begin
        x_busy = !(mq.size() >= BT);
        x_frm  = ev_frame;
        x_ovf  = 1'b0;
        if (mq.size() != 0 && out_ready) m_last = mq.pop_front();
        if (ev_push) begin
          if (mq.size() < DEPTH) mq.push_back(ev_ent);
          else x_ovf = 1'b1;
        end
      end
    end
  end

  int rdy_mode = 1;
  int rdy_ovr  = -1;
  logic [7:0] bq[$];

  task automatic drv(input logic d, input logic f, input logic v,
                     input bit p, input rx_entry_t e,
                     input bit fe, input bit rs);
    @(posedge clk);
    #1;
    din      = d;
    frame_n  = f;
    valid_n  = v;
    ev_push  = p;
    ev_ent   = e;
    ev_frame = fe;
    ev_rst   = rs;
    reset    = rs;
    if (rdy_ovr >= 0) out_ready = (rdy_ovr != 0);
    else if (rdy_mode == 2) out_ready = rb();
    else out_ready = (rdy_mode == 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(rb(), 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // ek: 0 none, 1 frame_n high in ADDR, 2 pad violation,
  // 3 frame_n high mid-payload, 4 reset during PAD.
  task automatic send(input logic [3:0] a, input logic [7:0] b[$],
                      input int gbit, input int glen,
                      input int ek, input int ep, input bit rlast);
    rx_entry_t e;
    int        nb;
    int        cnt;
    bit        last;
    nb  = b.size();
    cnt = 0;
    drv(a[0], 1'b0, rb(), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      if (ek == 1 && ep == i) begin
        drv(rb(), 1'b1, rb(), 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        return;
      end
      drv(a[i], 1'b0, rb(), 1'b0, '0, 1'b0, 1'b0);
    end
    for (int p = 0; p < PADC; p++) begin
      if (ek == 2 && ep == p) begin
        if (rb()) drv(rb(), 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        else drv(rb(), 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        return;
      end
      if (ek == 4 && ep == p) begin
        drv(rb(), 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
        return;
      end
      drv(rb(), 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    end
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (ek == 3 && cnt == ep) begin
          drv(rb(), 1'b1, rb(), 1'b0, '0, 1'b1, 1'b0);
          idle(1);
          return;
        end
        if (k == gbit) repeat (glen) drv(rb(), 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        last = (i == nb - 1) && (k == 7);
        e = '{addr: a, sop: (i == 0), eop: (i == nb - 1), data: b[i]};
        if (last && rlast) rdy_ovr = 1;
        drv(b[i][k], last, 1'b0, (k == 7), e, 1'b0, 1'b0);
        rdy_ovr = -1;
        cnt++;
      end
    end
    idle(1 + int'($urandom_range(0, 1)));
  endtask

  initial begin
    int nb;
    int ek;
    int ep;
    reset     = 1'b1;
    din       = 1'b0;
    frame_n   = 1'b1;
    valid_n   = 1'b1;
    out_ready = 1'b1;
    ev_rst    = 1'b1;
    @(posedge clk);
    #1;
    m_en = 1'b1;
    drv(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    idle(2);

    rdy_mode = 1;
    bq = {8'h3C, 8'hA5};
    send(4'hA, bq, -1, 0, 0, 0, 1'b0);

    bq = {8'h81};
    send(4'hA, bq, 4, 3, 0, 0, 1'b0);

    bq = {8'hC3};
    send(4'hA, bq, -1, 0, 3, 5, 1'b0);
    bq = {8'h55};
    send(4'h3, bq, -1, 0, 0, 0, 1'b0);

    rdy_mode = 0;
    bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send(4'h6, bq, -1, 0, 0, 0, 1'b0);
    rdy_mode = 1;
    idle(8);

    rdy_mode = 0;
    bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'hF0};
    send(4'h9, bq, -1, 0, 0, 0, 1'b1);
    rdy_mode = 1;
    idle(8);

    bq = {8'h99};
    send(4'h2, bq, -1, 0, 4, 2, 1'b0);
    bq = {8'h7E};
    send(4'h0, bq, -1, 0, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rdy_mode = int'($urandom_range(0, 2));
      nb = int'($urandom_range(1, 5));
      bq.delete();
      for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
      ek = 0;
      ep = 0;
      if ($urandom_range(0, 4) == 0) begin
        ek = int'($urandom_range(1, 4));
        case (ek)
          1: ep = int'($urandom_range(1, 3));
          3: begin
            ep = int'($urandom_range(0, nb * 8 - 1));
            if (ep % 8 == 7) ep = ep - 1;
          end
          default: ep = int'($urandom_range(0, PADC - 1));
        endcase
      end
      send(4'($urandom), bq,
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
           int'($urandom_range(1, 3)), ek, ep, 1'b0);
      if (rdy_mode == 0) begin
        rdy_mode = 2;
        idle(int'($urandom_range(0, 6)));
      end
    end

    rdy_mode = 1;
    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
